// File: rtl/ref_mem_ctrl_gen.sv
// Reference-frame memory controller for the HEVC ME datapath.
// The controller works in three phases:
//   1. Preload: fills the banked reference RAM one group of banks at a time,
//      taking one line per accepted valid/ready write.
//   2. Prime: reads the first search point's rows into the PE read registers.
//   3. Search: streams the remaining rows whenever the PE array asks for one.
// Ports:
//   clk, rst_n         clock and asynchronous active-low reset
//   begin_prepare      start pulse, only sampled in IDLE
//   wr_valid/wr_ready  preload line handshake
//   row_adv            PE request for the next search row
//   Bank_sel           one-hot-group per-bank write enable
//   write_address_all  write address, replicated across all banks
//   rd_address_all     read address, replicated across all banks
//   rd8R_en            active-low read enable
//   rdR_sel            destination PE read register
//   busy, done         activity flag and end-of-sequence pulse
module ref_mem_ctrl_gen #(
  parameter int unsigned NUM_BANK    = 32,
  parameter int unsigned GROUP_BANKS = 4,
  parameter int unsigned LINES       = 96,
  parameter int unsigned ADDR_W      = 7,
  parameter int unsigned PRIME_ROWS  = 4,
  parameter int unsigned RD_REGS     = 8
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       begin_prepare,
  input  logic                       wr_valid,
  output logic                       wr_ready,
  input  logic                       row_adv,
  output logic [NUM_BANK-1:0]        Bank_sel,
  output logic [NUM_BANK*ADDR_W-1:0] write_address_all,
  output logic [NUM_BANK*ADDR_W-1:0] rd_address_all,
  output logic                       rd8R_en,
  output logic [3:0]                 rdR_sel,
  output logic                       busy,
  output logic                       done
);

  localparam int unsigned G  = NUM_BANK / GROUP_BANKS;
  localparam int unsigned GW = (G > 1) ? $clog2(G) : 1;
  localparam int unsigned CW = ADDR_W + 1;

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_PRELOAD = 3'd1;
  localparam logic [2:0] S_PRIME   = 3'd2;
  localparam logic [2:0] S_SEARCH  = 3'd3;
  localparam logic [2:0] S_DONE    = 3'd4;

  localparam logic [GW-1:0]       LAST_G     = GW'(G - 1);
  localparam logic [CW-1:0]       LAST_LINE  = CW'(LINES - 1);
  localparam logic [CW-1:0]       LAST_PRIME = CW'(PRIME_ROWS - 1);
  localparam logic [CW-1:0]       LINES_C    = CW'(LINES);
  // The low GROUP_BANKS bits are set. This mask is shifted into place per group.
  localparam logic [NUM_BANK-1:0] GROUP_MASK = ~({NUM_BANK{1'b1}} << GROUP_BANKS);

  logic [2:0]                 state, state_nxt;
  logic [GW-1:0]              g, g_nxt;
  logic [CW-1:0]              l, l_nxt;
  logic [CW-1:0]              r, r_nxt;
  logic [NUM_BANK-1:0]        bank_nxt;
  logic [NUM_BANK*ADDR_W-1:0] waddr_nxt;
  logic [NUM_BANK*ADDR_W-1:0] raddr_nxt;
  logic                       rden_nxt;
  logic [3:0]                 sel_nxt;
  logic                       wrr_nxt;
  logic                       busy_nxt;
  logic                       done_nxt;

  // State, counters and all registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state             <= S_IDLE;
      g                 <= '0;
      l                 <= '0;
      r                 <= '0;
      Bank_sel          <= '0;
      write_address_all <= '0;
      rd_address_all    <= '0;
      rd8R_en           <= 1'b1;
      rdR_sel           <= '0;
      wr_ready          <= 1'b0;
      busy              <= 1'b0;
      done              <= 1'b0;
    end else begin
      state             <= state_nxt;
      g                 <= g_nxt;
      l                 <= l_nxt;
      r                 <= r_nxt;
      Bank_sel          <= bank_nxt;
      write_address_all <= waddr_nxt;
      rd_address_all    <= raddr_nxt;
      rd8R_en           <= rden_nxt;
      rdR_sel           <= sel_nxt;
      wr_ready          <= wrr_nxt;
      busy              <= busy_nxt;
      done              <= done_nxt;
    end
  end

  // Next-state and next-output logic. Addresses and select hold unless overwritten.
  always_comb begin
    state_nxt = state;
    g_nxt     = g;
    l_nxt     = l;
    r_nxt     = r;
    bank_nxt  = '0;
    waddr_nxt = write_address_all;
    raddr_nxt = rd_address_all;
    rden_nxt  = 1'b1;
    sel_nxt   = rdR_sel;
    wrr_nxt   = 1'b0;
    busy_nxt  = 1'b1;
    done_nxt  = 1'b0;

    case (state)
      S_IDLE: begin
        waddr_nxt = '0;
        raddr_nxt = '0;
        sel_nxt   = '0;
        g_nxt     = '0;
        l_nxt     = '0;
        r_nxt     = '0;
        busy_nxt  = begin_prepare;
        if (begin_prepare) begin
          state_nxt = S_PRELOAD;
          wrr_nxt   = 1'b1;
        end
      end

      S_PRELOAD: begin
        wrr_nxt = 1'b1;
        if (wr_valid && wr_ready) begin
          bank_nxt  = GROUP_MASK << (32'(g) * GROUP_BANKS);
          waddr_nxt = {NUM_BANK{l[ADDR_W-1:0]}};
          if (l == LAST_LINE) begin
            l_nxt = '0;
            g_nxt = g + GW'(1);
            if (g == LAST_G) begin
              state_nxt = S_PRIME;
              wrr_nxt   = 1'b0;
            end
          end else begin
            l_nxt = l + CW'(1);
          end
        end
      end

      // Unconditional reads of rows 0..PRIME_ROWS-1.
      S_PRIME: begin
        rden_nxt  = 1'b0;
        raddr_nxt = {NUM_BANK{r[ADDR_W-1:0]}};
        sel_nxt   = 4'(32'(r) % RD_REGS);
        r_nxt     = r + CW'(1);
        if (r == LAST_LINE) begin
          state_nxt = S_DONE;
        end else if (r == LAST_PRIME) begin
          state_nxt = S_SEARCH;
        end
      end

      // One read per row_adv; stalls keep address and select.
      S_SEARCH: begin
        if (row_adv && (r < LINES_C)) begin
          rden_nxt  = 1'b0;
          raddr_nxt = {NUM_BANK{r[ADDR_W-1:0]}};
          sel_nxt   = 4'(32'(r) % RD_REGS);
          r_nxt     = r + CW'(1);
          if (r == LAST_LINE) begin
            state_nxt = S_DONE;
          end
        end
      end

      S_DONE: begin
        done_nxt  = 1'b1;
        state_nxt = S_IDLE;
      end

      default: begin
        state_nxt = S_IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_ref_mem_ctrl_gen.sv
// Testbench for ref_mem_ctrl_gen.
// The default-parameter instance is checked every cycle against a
// transaction-count reference model. The model counts the lines written and
// the rows read.
// A small instance (two groups, no search phase) is checked against a
// cycle-by-cycle vector table.
module tb_ref_mem_ctrl_gen;

  localparam int NB = 32, GB = 4, L = 96, AW = 7, P = 4, RD = 8;
  localparam int TOTAL = (NB / GB) * L;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n;

  logic            bp, wv, ra, wrr, rden, busy, done;
  logic [NB-1:0]   bank;
  logic [NB*AW-1:0] waddr, raddr;
  logic [3:0]      sel;

  logic            bp2, wv2, ra2, wrr2, rden2, busy2, done2;
  logic [15:0]     bank2;
  logic [47:0]     waddr2, raddr2;
  logic [3:0]      sel2;

  ref_mem_ctrl_gen dut (
    .clk(clk), .rst_n(rst_n), .begin_prepare(bp), .wr_valid(wv), .wr_ready(wrr),
    .row_adv(ra), .Bank_sel(bank), .write_address_all(waddr), .rd_address_all(raddr),
    .rd8R_en(rden), .rdR_sel(sel), .busy(busy), .done(done)
  );

  ref_mem_ctrl_gen #(
    .NUM_BANK(16), .GROUP_BANKS(8), .LINES(8), .ADDR_W(3), .PRIME_ROWS(8), .RD_REGS(8)
  ) dut_small (
    .clk(clk), .rst_n(rst_n), .begin_prepare(bp2), .wr_valid(wv2), .wr_ready(wrr2),
    .row_adv(ra2), .Bank_sel(bank2), .write_address_all(waddr2), .rd_address_all(raddr2),
    .rd8R_en(rden2), .rdR_sel(sel2), .busy(busy2), .done(done2)
  );

  int errors = 0;
  int checks = 0;
  int n_wcyc, n_rcyc, n_done, n_busy;

  task automatic chk(input string name, input logic [255:0] got, input logic [255:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s @%0t: got=%0h expected=%0h", name, $time, got, exp);
    end
  endtask

  // Reference model: counts lines written (m_n) and rows read (m_r).
  bit         m_active;
  int         m_n, m_r;
  logic [31:0] e_bank;
  int         e_wline, e_rrow, e_sel;
  logic       e_rden, e_wrr, e_busy, e_done;

  task model_reset();
    m_active = 0; m_n = 0; m_r = 0;
    e_bank = '0; e_wline = 0; e_rrow = 0; e_sel = 0;
    e_rden = 1'b1; e_wrr = 1'b0; e_busy = 1'b0; e_done = 1'b0;
  endtask

  task model_edge(input logic b, input logic w, input logic a);
    e_bank = '0; e_rden = 1'b1; e_done = 1'b0; e_wrr = 1'b0;
    if (!m_active) begin
      e_wline = 0; e_rrow = 0; e_sel = 0;
      if (b) begin
        m_active = 1; m_n = 0; m_r = 0; e_wrr = 1'b1;
      end
    end else if (m_n < TOTAL) begin
      if (w) begin
        e_bank  = 32'hF << ((m_n / L) * GB);
        e_wline = m_n % L;
        m_n++;
      end
      e_wrr = (m_n < TOTAL);
    end else if (m_r < P || (m_r < L && a)) begin
      e_rden = 1'b0; e_rrow = m_r; e_sel = m_r % RD;
      m_r++;
    end else if (m_r == L) begin
      e_done = 1'b1; m_active = 0;
    end
    e_busy = m_active | e_done;
  endtask

  task compare_big(input string tag);
    chk({tag, " Bank_sel"}, bank, e_bank);
    chk({tag, " write_address_all"}, waddr, {NB{7'(e_wline)}});
    chk({tag, " rd_address_all"}, raddr, {NB{7'(e_rrow)}});
    chk({tag, " {rd8R_en,rdR_sel,wr_ready,busy,done}"}, {rden, sel, wrr, busy, done},
        {e_rden, 4'(e_sel), e_wrr, e_busy, e_done});
    if (bank != '0) n_wcyc++;
    if (!rden) n_rcyc++;
    if (done) n_done++;
    if (busy) n_busy++;
  endtask

  task automatic step(input logic b, input logic w, input logic a);
    bp = b; wv = w; ra = a;
    @(posedge clk);
    model_edge(b, w, a);
    @(negedge clk);
    compare_big("big");
  endtask

  task do_reset();
    bp = 1'b0; wv = 1'b0; ra = 1'b0;
    rst_n = 1'b0;
    #1;
    model_reset();
    compare_big("async reset");
    @(negedge clk);
    compare_big("reset held");
    rst_n = 1'b1;
  endtask

  // wmode: 0 continuous, 1 one-in-three, 2 random; rmode: 0 always, 1 random.
  task automatic run_seq(input int wmode, input int rmode, input int budget, input int exp_busy);
    bit   fin;
    logic w, a;
    fin = 0; n_wcyc = 0; n_rcyc = 0; n_done = 0; n_busy = 0;
    step(1'b1, 1'b0, 1'b0);
    for (int c = 0; c < budget && !fin; c++) begin
      w = (wmode == 0) ? 1'b1 : (wmode == 1) ? (c % 3 == 0) : 1'($urandom_range(0, 1));
      a = (rmode == 0) ? 1'b1 : 1'($urandom_range(0, 1));
      step(1'($urandom_range(0, 1)), w, a);
      if (e_done) fin = 1;
    end
    chk("run reached done within budget", 256'(fin), 256'(1));
    step(1'b0, 1'b0, 1'b0);
    chk("write cycles", n_wcyc, TOTAL);
    chk("read cycles", n_rcyc, L);
    chk("done pulses", n_done, 1);
    if (exp_busy > 0) chk("busy cycles", n_busy, exp_busy);
  endtask

  typedef struct {
    logic bp; logic wv; logic ra;
    logic [15:0] bank; int wline; int rrow;
    logic rden; int sel; logic wrr; logic busy; logic done;
  } vec_t;

  vec_t tv[29];

  function automatic vec_t mk(input logic b, input logic w, input logic a, input logic [15:0] bk,
                              input int wl, input int rr, input logic re, input int s,
                              input logic wr, input logic bz, input logic dn);
    vec_t v;
    v.bp = b; v.wv = w; v.ra = a; v.bank = bk; v.wline = wl; v.rrow = rr;
    v.rden = re; v.sel = s; v.wrr = wr; v.busy = bz; v.done = dn;
    return v;
  endfunction

  initial begin
    #1ms;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    // Small instance: two groups of 8 lines, prime covers every row, so search is skipped.
    tv[0] = mk(1, 0, 0, 16'h0000, 0, 0, 1, 0, 1, 1, 0);
    for (int i = 0; i < 8; i++) tv[1 + i] = mk((i == 2), 1, 0, 16'h00FF, i, 0, 1, 0, 1, 1, 0);
    tv[9] = mk(0, 0, 0, 16'h0000, 7, 0, 1, 0, 1, 1, 0);
    for (int i = 0; i < 8; i++) tv[10 + i] = mk(0, 1, 0, 16'hFF00, i, 0, 1, 0, (i < 7), 1, 0);
    for (int i = 0; i < 8; i++) tv[18 + i] = mk((i == 2), 1, 1, 16'h0000, 7, i, 0, i, 0, 1, 0);
    tv[26] = mk(0, 0, 0, 16'h0000, 7, 7, 1, 7, 0, 1, 1);
    tv[27] = mk(0, 0, 1, 16'h0000, 0, 0, 1, 0, 0, 0, 0);
    tv[28] = mk(0, 1, 0, 16'h0000, 0, 0, 1, 0, 0, 0, 0);

    rst_n = 1'b0;
    bp = 1'b0; wv = 1'b0; ra = 1'b0;
    bp2 = 1'b0; wv2 = 1'b0; ra2 = 1'b0;
    n_wcyc = 0; n_rcyc = 0; n_done = 0; n_busy = 0;
    model_reset();
    @(negedge clk);
    @(negedge clk);
    compare_big("power-on reset");
    chk("small reset {Bank_sel,rd8R_en,wr_ready,busy,done}",
        {bank2, rden2, wrr2, busy2, done2}, {16'h0000, 1'b1, 3'b000});
    chk("small reset addresses", {waddr2, raddr2, sel2}, '0);
    rst_n = 1'b1;

    for (int i = 0; i < 29; i++) begin
      bp2 = tv[i].bp; wv2 = tv[i].wv; ra2 = tv[i].ra;
      @(posedge clk);
      @(negedge clk);
      chk($sformatf("vec%0d Bank_sel", i), bank2, tv[i].bank);
      chk($sformatf("vec%0d write_address_all", i), waddr2, {16{3'(tv[i].wline)}});
      chk($sformatf("vec%0d rd_address_all", i), raddr2, {16{3'(tv[i].rrow)}});
      chk($sformatf("vec%0d {rd8R_en,rdR_sel,wr_ready,busy,done}", i),
          {rden2, sel2, wrr2, busy2, done2},
          {tv[i].rden, 4'(tv[i].sel), tv[i].wrr, tv[i].busy, tv[i].done});
    end
    bp2 = 1'b0; wv2 = 1'b0; ra2 = 1'b0;

    // Reset in the middle of preload at group 3, line 40, then restart from scratch.
    do_reset();
    step(1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 3 * L + 40; i++) step(1'b0, 1'b1, 1'b0);
    chk("pre-reset Bank_sel (group 3)", bank, 32'h0000_F000);
    chk("pre-reset write_address_all (line 39)", waddr, {NB{7'd39}});
    do_reset();
    step(1'b1, 1'b0, 1'b0);
    step(1'b0, 1'b1, 1'b0);
    chk("restart Bank_sel", bank, 32'h0000_000F);
    chk("restart write_address_all", waddr, '0);
    do_reset();

    // Full sequences: continuous, one-in-three writes with random row_adv, fully random.
    run_seq(0, 0, 2000, 1 + TOTAL + L + 1);
    run_seq(1, 1, 4000, 0);
    run_seq(2, 1, 4000, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
